// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one cbus port among NUM_REQ requesters (e.g. I-side and
// D-side mmu) in front of the memory interconnect. A grant is held until the
// downstream response beat carrying `last` is accepted, then the bus idles
// for one cycle before the next grant.
// Optional feature macro: CBUS_ARB_RR_EN
//   defined   -> round-robin arbitration starting at rr_ptr
//   undefined -> fixed priority, lowest valid index wins
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
    logic        err;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  cbus_req_t  [NUM_REQ-1:0] ireq,
  output cbus_resp_t [NUM_REQ-1:0] iresp,
  output cbus_req_t                oreq,
  input  cbus_resp_t               oresp,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_idx
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] winner;
  logic             any_valid;

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;
  logic             rr_advance;

  // Pick the first valid requester scanning upward from rr_ptr, wrapping.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] idx;
    cand      = '0;
    idx       = '0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_REQ;
      idx  = IDX_W'(cand);
      if (!any_valid && ireq[idx].valid) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

  assign rr_advance = (state_q == GRANT) && oresp.ready && oresp.last;

  // Advance the round-robin pointer past the holder when its grant completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (rr_advance) begin
      rr_ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end
`else
  // Fixed priority: the lowest valid index wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_valid && ireq[IDX_W'(k)].valid) begin
        winner    = IDX_W'(k);
        any_valid = 1'b1;
      end
    end
  end
`endif

  // Next-state: arbitrate only in IDLE; release only on an accepted last beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = GRANT;
          grant_d = winner;
        end
      end
      GRANT: begin
        if (oresp.ready && oresp.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant-holder registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Routing: pass the holder's request down and the response back to it only.
  always_comb begin
    oreq  = '0;
    iresp = '0;
    if (state_q == GRANT) begin
      oreq           = ireq[grant_q];
      iresp[grant_q] = oresp;
    end
  end

  assign busy      = (state_q == GRANT);
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model of ownership.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N  = 2;
  localparam int IW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  cbus_req_t  [N-1:0]   ireq = '0;
  cbus_resp_t [N-1:0]   iresp;
  cbus_req_t            oreq;
  cbus_resp_t           oresp = '0;
  logic                 busy;
  logic [IW-1:0]        grant_idx;

  int passed = 0;
  int total  = 0;

  // Reference model: who owns the bus (-1 = nobody), last owner, rr start.
  int m_owner = -1;
  int m_last  = 0;
  int m_rr    = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .ireq      (ireq),
    .iresp     (iresp),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic cbus_req_t mk_req(logic [31:0] a, logic w, logic [7:0] l);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = w;
    r.size     = 3'($urandom_range(0, 3));
    r.addr     = a;
    r.strobe   = 4'($urandom);
    r.data     = $urandom;
    r.len      = l;
    r.burst    = 2'($urandom);
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(logic rdy, logic lst, logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = d;
    r.err   = 1'($urandom);
    return r;
  endfunction

  // Ownership rules: arbitrate only when nobody owns the bus, release on ready&last.
  task automatic model_update();
    if (rst) begin
      m_owner = -1;
      m_last  = 0;
      m_rr    = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (ireq[IW'(i)].valid) begin
          m_owner = i;
          m_last  = i;
          break;
        end
      end
    end else if (oresp.ready && oresp.last) begin
`ifdef CBUS_ARB_RR_EN
      m_rr = (m_owner + 1) % N;
`endif
      m_owner = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic reset_dut();
    rst   = 1'b1;
    ireq  = '0;
    oresp = '0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    ireq[0] = mk_req($urandom, 1'b0, 8'd0);
    ireq[1] = mk_req($urandom, 1'b1, 8'd0);
    oresp   = mk_resp(1'b1, 1'b1, $urandom);
    tick();
    tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (grant_idx !== '0) $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); else passed++;
    total++; if (oreq !== '0) $display("FAIL reset_oreq: got %h want 0", oreq); else passed++;
    total++; if (iresp !== '0) $display("FAIL reset_iresp: got %h want 0", iresp); else passed++;
    rst   = 1'b0;
    oresp = '0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL arb_latency_busy: got %b want 0", busy); else passed++;
    tick();
    total++; if (busy !== 1'b1 || grant_idx !== IW'(0)) $display("FAIL first_grant: busy=%b idx=%0d want 1/0", busy, grant_idx); else passed++;
    total++; if (oreq !== ireq[0]) $display("FAIL first_grant_oreq: got %h want %h", oreq, ireq[0]); else passed++;
  endtask

  task automatic test_single();
    cbus_resp_t r;
    reset_dut();
    ireq[1] = mk_req(32'h8000_0000, 1'b0, 8'd0);
    #1;
    total++; if (oreq.valid !== 1'b0) $display("FAIL single_pre_valid: got %b want 0", oreq.valid); else passed++;
    tick();
    total++; if (grant_idx !== IW'(1) || busy !== 1'b1) $display("FAIL single_grant: idx=%0d busy=%b want 1/1", grant_idx, busy); else passed++;
    total++; if (oreq.valid !== 1'b1 || oreq.addr !== 32'h8000_0000 || oreq.is_write !== 1'b0) $display("FAIL single_oreq: v=%b addr=%h w=%b want 1/80000000/0", oreq.valid, oreq.addr, oreq.is_write); else passed++;
    total++; if (oreq !== ireq[1]) $display("FAIL single_passthru: got %h want %h", oreq, ireq[1]); else passed++;
    r     = mk_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
    oresp = r;
    #1;
    total++; if (iresp[1].data !== 32'hDEAD_BEEF || iresp[1] !== r) $display("FAIL single_iresp1: got %h want %h", iresp[1], r); else passed++;
    total++; if (iresp[0] !== '0) $display("FAIL single_iresp0: got %h want 0", iresp[0]); else passed++;
    tick();
    ireq  = '0;
    oresp = '0;
    #1;
    total++; if (busy !== 1'b0 || oreq !== '0) $display("FAIL single_release: busy=%b oreq=%h want 0/0", busy, oreq); else passed++;
    total++; if (grant_idx !== IW'(1)) $display("FAIL single_last_holder: got %0d want 1", grant_idx); else passed++;
  endtask

  task automatic test_contention();
    int   cnt       = 0;
    int   ng        = 0;
    int   idle_run  = 0;
    logic prev_busy = 1'b0;
    int   exp_seq [4];
`ifdef CBUS_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    reset_dut();
    ireq[0] = mk_req(32'h1000, 1'b0, 8'd0);
    ireq[1] = mk_req(32'h2000, 1'b1, 8'd0);
    for (int c = 0; c < 16; c++) begin
      tick();
      if (m_owner >= 0) cnt++; else cnt = 0;
      oresp = (cnt == 3) ? mk_resp(1'b1, 1'b1, $urandom) : '0;
      #1;
      if (busy && !prev_busy) begin
        if (ng < 4) begin
          total++; if (grant_idx !== IW'(exp_seq[ng])) $display("FAIL contention_grant%0d: got %0d want %0d", ng, grant_idx, exp_seq[ng]); else passed++;
        end
        if (ng > 0) begin
          total++; if (idle_run !== 1) $display("FAIL contention_gap%0d: got %0d idle cycles want 1", ng, idle_run); else passed++;
        end
        ng++;
        idle_run = 0;
      end
      if (!busy) idle_run++;
      prev_busy = busy;
    end
    total++; if (ng !== 4) $display("FAIL contention_count: got %0d grants want 4", ng); else passed++;
    ireq[0].valid = 1'b0;
    tick();
    total++; if (busy !== 1'b1 || grant_idx !== IW'(1)) $display("FAIL contention_req1: busy=%b idx=%0d want 1/1", busy, grant_idx); else passed++;
    oresp = mk_resp(1'b1, 1'b1, $urandom);
    tick();
    ireq  = '0;
    oresp = '0;
  endtask

  task automatic test_burst();
    cbus_resp_t r;
    reset_dut();
    ireq[0] = mk_req(32'h4000, 1'b0, 8'd3);
    ireq[1] = mk_req(32'h5000, 1'b0, 8'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      r     = mk_resp(1'b1, (b == 3), $urandom);
      oresp = r;
      #1;
      total++; if (iresp[0] !== r) $display("FAIL burst_beat%0d_iresp0: got %h want %h", b, iresp[0], r); else passed++;
      total++; if (iresp[1] !== '0) $display("FAIL burst_beat%0d_iresp1: got %h want 0", b, iresp[1]); else passed++;
      total++; if (busy !== 1'b1 || grant_idx !== IW'(0)) $display("FAIL burst_beat%0d_grant: busy=%b idx=%0d want 1/0", b, busy, grant_idx); else passed++;
      tick();
    end
    ireq[0].valid = 1'b0;
    oresp         = '0;
    #1;
    total++; if (busy !== 1'b0 || grant_idx !== IW'(0)) $display("FAIL burst_idle_gap: busy=%b idx=%0d want 0/0", busy, grant_idx); else passed++;
    tick();
    total++; if (busy !== 1'b1 || grant_idx !== IW'(1)) $display("FAIL burst_next_grant: busy=%b idx=%0d want 1/1", busy, grant_idx); else passed++;
    oresp = mk_resp(1'b1, 1'b1, $urandom);
    tick();
    ireq  = '0;
    oresp = '0;
  endtask

  task automatic test_drop_valid();
    reset_dut();
    ireq[0] = mk_req(32'h6000, 1'b1, 8'd0);
    tick();
    ireq[0].valid = 1'b0;
    ireq[1]       = mk_req(32'h7000, 1'b0, 8'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (oreq.valid !== 1'b0) $display("FAIL drop_oreq_valid%0d: got %b want 0", c, oreq.valid); else passed++;
      total++; if (busy !== 1'b1 || grant_idx !== IW'(0)) $display("FAIL drop_hold%0d: busy=%b idx=%0d want 1/0", c, busy, grant_idx); else passed++;
      oresp = (c == 1) ? mk_resp(1'b1, 1'b0, $urandom) : '0;
      tick();
    end
    oresp = mk_resp(1'b1, 1'b1, $urandom);
    tick();
    oresp = '0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL drop_release: got busy %b want 0", busy); else passed++;
    tick();
    total++; if (busy !== 1'b1 || grant_idx !== IW'(1)) $display("FAIL drop_next_grant: busy=%b idx=%0d want 1/1", busy, grant_idx); else passed++;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    ireq[1] = mk_req(32'h9000, 1'b0, 8'd2);
    tick();
    total++; if (busy !== 1'b1 || grant_idx !== IW'(1)) $display("FAIL rstmid_pre: busy=%b idx=%0d want 1/1", busy, grant_idx); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || oreq.valid !== 1'b0) $display("FAIL rstmid_idle: busy=%b valid=%b want 0/0", busy, oreq.valid); else passed++;
    total++; if (grant_idx !== IW'(0)) $display("FAIL rstmid_grant_idx: got %0d want 0", grant_idx); else passed++;
    ireq[0] = mk_req(32'hA000, 1'b1, 8'd0);
    tick();
    total++; if (busy !== 1'b1 || grant_idx !== IW'(0)) $display("FAIL rstmid_restart: busy=%b idx=%0d want 1/0", busy, grant_idx); else passed++;
  endtask

  task automatic test_random();
    cbus_req_t          e_oreq;
    cbus_resp_t [N-1:0] e_iresp;
    logic               e_busy;
    logic [IW-1:0]      e_gidx;
    reset_dut();
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        ireq[i]       = mk_req($urandom, 1'($urandom), 8'($urandom_range(0, 3)));
        ireq[i].valid = ($urandom_range(0, 9) < 5);
      end
      oresp = mk_resp(1'($urandom), ($urandom_range(0, 2) == 0), $urandom);
      #1;
      e_oreq  = '0;
      e_iresp = '0;
      if (m_owner >= 0) begin
        e_oreq               = ireq[IW'(m_owner)];
        e_iresp[IW'(m_owner)] = oresp;
      end
      e_busy = (m_owner >= 0);
      e_gidx = IW'(m_last);
      total++;
      if (oreq !== e_oreq || iresp !== e_iresp || busy !== e_busy || grant_idx !== e_gidx)
        $display("FAIL random_cyc%0d: busy=%b/%b idx=%0d/%0d oreq=%h/%h iresp=%h/%h (got/want)",
                 c, busy, e_busy, grant_idx, e_gidx, oreq, e_oreq, iresp, e_iresp);
      else
        passed++;
      tick();
    end
    rst   = 1'b0;
    ireq  = '0;
    oresp = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_drop_valid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
